// File: rtl/nonce_tx_pkg.sv
// Shared types and constants for the nonce TX serializer and its word FIFO.
package nonce_tx_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_DONE
    } txState_t;

    // Bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/nonce_tx_fifo.sv
// Synchronous word FIFO with registered occupancy count; pushes while full are ignored.
module nonce_tx_fifo
    import nonce_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push & ~full;
    assign doPop    = pop & ~empty;
    assign headData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            if (doPush && !doPop) begin
                count <= count + CNT_W'(1);
            end else if (!doPush && doPop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/nonce_tx_serializer.sv
// Buffers result words and feeds them byte by byte to the UART TX over start/busy.
// Define NONCE_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module nonce_tx_serializer
    import nonce_tx_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         word_valid,
    input  logic [BYTE_W*WORD_BYTES-1:0] word_data,
    output logic                         word_ready,
    output logic                         tx_start,
    output logic [BYTE_W-1:0]            tx_data,
    input  logic                         tx_busy,
    output logic                         overflow,
    output logic                         idle
);

    localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
`ifdef NONCE_TX_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = WORD_BYTES + 1;
`else
    localparam int unsigned FRAME_BYTES = WORD_BYTES;
`endif
    localparam int unsigned CNT_W = clog2(WORD_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    txState_t          state;
    logic [WORD_W-1:0] shiftReg;
    logic [WORD_W-1:0] nextShift;
    logic [WORD_W-1:0] headWord;
    logic [CNT_W-1:0]  byteCnt;
    logic [BYTE_W-1:0] nextByte;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pop;

    function automatic logic [BYTE_W-1:0] curByte(input logic [WORD_W-1:0] w);
        if (LSB_FIRST) return w[BYTE_W-1:0];
        return w[WORD_W-1 -: BYTE_W];
    endfunction

    function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
        if (LSB_FIRST) return w >> BYTE_W;
        return w << BYTE_W;
    endfunction

    nonce_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (word_valid),
        .pushData (word_data),
        .pop      (pop),
        .headData (headWord),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Never pop while the transmitter is still finishing a byte (e.g. after a reset).
    assign pop        = (state == S_IDLE) & ~fifoEmpty & ~tx_busy;
    assign word_ready = ~fifoFull;
    assign idle       = fifoEmpty & (state == S_IDLE) & ~tx_busy;
    assign nextShift  = advance(shiftReg);

`ifdef NONCE_TX_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;

    function automatic logic [BYTE_W-1:0] xorBytes(input logic [WORD_W-1:0] w);
        logic [BYTE_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            acc = acc ^ w[i*BYTE_W +: BYTE_W];
        end
        return acc;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (pop) begin
            csum <= xorBytes(headWord);
        end
    end

    // The byte after the last data byte is the checksum.
    assign nextByte = (byteCnt == CNT_W'(WORD_BYTES - 1)) ? csum : curByte(nextShift);
`else
    assign nextByte = curByte(nextShift);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shiftReg <= '0;
            byteCnt  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= word_valid & fifoFull;
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shiftReg <= headWord;
                        byteCnt  <= '0;
                        tx_data  <= curByte(headWord);
                        tx_start <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: state <= S_ACK;
                S_ACK: begin
                    if (tx_busy) state <= S_DONE;
                end
                S_DONE: begin
                    if (!tx_busy) begin
                        if (byteCnt == LAST_IDX) begin
                            state <= S_IDLE;
                        end else begin
                            shiftReg <= nextShift;
                            byteCnt  <= byteCnt + CNT_W'(1);
                            tx_data  <= nextByte;
                            tx_start <= 1'b1;
                            state    <= S_START;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_tx_serializer.sv
// Bench for nonce_tx_serializer: directed frames, overflow, reset mid-word and random traffic
// against a byte-queue reference model; honours NONCE_TX_CHECKSUM_EN.
module tb_nonce_tx_serializer;

    localparam int unsigned WB    = 4;
    localparam int unsigned DEPTH = 4;
`ifdef NONCE_TX_CHECKSUM_EN
    localparam int unsigned FRAME = WB + 1;
`else
    localparam int unsigned FRAME = WB;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        overflow;
    logic        idle;

    logic        wordValidM;
    logic [31:0] wordDataM;
    logic        wordReadyM;
    logic        txStartM;
    logic [7:0]  txDataM;
    logic        txBusyM;
    logic        overflowM;
    logic        idleM;

    always #5 clk = ~clk;

    nonce_tx_serializer #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .overflow(overflow), .idle(idle)
    );

    nonce_tx_serializer #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0)) dutMsb (
        .clk(clk), .rst(rst), .word_valid(wordValidM), .word_data(wordDataM),
        .word_ready(wordReadyM), .tx_start(txStartM), .tx_data(txDataM),
        .tx_busy(txBusyM), .overflow(overflowM), .idle(idleM)
    );

    int compared = 0;
    int mismatched = 0;
    int tickNo = 0;
    int fallTick = 0;
    int busyLeft = 0;
    int busyLeftM = 0;
    int kCycles = 10;
    int accWords = 0;
    int framesBegun = 0;
    int bytesSent = 0;
    int starts = 0;
    bit startPrev = 1'b0;
    bit startPrevM = 1'b0;
    bit heldValid = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] expQ [$];
    logic [7:0] sentLog [$];
    logic [7:0] sentM [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected transmit order of one accepted word (LSB first, optional XOR byte).
    task automatic modelPush(input logic [31:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int b = 0; b < int'(WB); b++) begin
            expQ.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
        end
`ifdef NONCE_TX_CHECKSUM_EN
        expQ.push_back(x);
`endif
        accWords++;
    endtask

    // One clock: apply inputs, sample #1 after the edge, check, then run the transmitter models.
    task automatic tick();
        logic        validPre;
        logic        readyPre;
        logic        rstPre;
        logic [31:0] dataPre;
        validPre = word_valid;
        dataPre  = word_data;
        rstPre   = rst;
        readyPre = ((accWords - framesBegun) < int'(DEPTH));
        @(posedge clk);
        #1;
        tickNo++;
        if (rstPre) begin
            expQ.delete();
            accWords    = 0;
            framesBegun = 0;
            bytesSent   = 0;
            heldValid   = 1'b0;
        end else if (validPre && readyPre) begin
            modelPush(dataPre);
        end
        if (tx_start === 1'b1) begin
            starts++;
            check("startWhileBusy", 32'(tx_busy), 32'(0));
            if (expQ.size() == 0) begin
                check("unexpectedStart", 32'(1), 32'(0));
            end else begin
                check("txByte", 32'(tx_data), 32'(expQ.pop_front()));
            end
            if ((bytesSent % int'(FRAME)) != 0) check("byteGap", 32'(tickNo - fallTick), 32'(1));
            else framesBegun++;
            bytesSent++;
            held      = tx_data;
            heldValid = 1'b1;
            sentLog.push_back(tx_data);
        end else if (tx_busy && heldValid) begin
            check("txDataStable", 32'(tx_data), 32'(held));
        end
        check("wordReady", 32'(word_ready), 32'((accWords - framesBegun) < int'(DEPTH)));
        check("overflow", 32'(overflow), 32'(validPre && !readyPre && !rstPre));
        if (rstPre) check("rstTxData", 32'(tx_data), 32'(0));
        if (idle === 1'b1) check("idleDrained", 32'(expQ.size() == 0 && !tx_busy), 32'(1));
        if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) begin
                tx_busy  = 1'b0;
                fallTick = tickNo;
            end
        end
        if (startPrev) begin
            tx_busy  = 1'b1;
            busyLeft = kCycles;
        end
        startPrev = (tx_start === 1'b1);
        if (txStartM === 1'b1) sentM.push_back(txDataM);
        if (busyLeftM > 0) begin
            busyLeftM--;
            if (busyLeftM == 0) txBusyM = 1'b0;
        end
        if (startPrevM) begin
            txBusyM   = 1'b1;
            busyLeftM = 3;
        end
        startPrevM = (txStartM === 1'b1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && !tx_busy && idle === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n < budget), 32'(1));
    endtask

    initial begin
        logic [7:0] exp1 [5];
        logic [7:0] exp4 [5];
        int base;
        int n;
        exp1 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        exp4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};

        rst = 1'b1; word_valid = 1'b0; word_data = '0; tx_busy = 1'b0;
        wordValidM = 1'b0; wordDataM = '0; txBusyM = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("resetStart", 32'(tx_start), 32'(0));
        check("resetOverflow", 32'(overflow), 32'(0));
        check("resetReady", 32'(word_ready), 32'(1));
        check("resetIdle", 32'(idle), 32'(1));

        // Single word 0xDEADBEEF: latency, byte order, start count.
        kCycles = 10;
        sentLog.delete();
        base = starts;
        word_valid = 1'b1; word_data = 32'hDEADBEEF;
        tick();
        word_valid = 1'b0;
        check("latNoStartYet", 32'(tx_start), 32'(0));
        check("latNotIdle", 32'(idle), 32'(0));
        tick();
        check("latStart", 32'(tx_start), 32'(1));
        check("latFirstByte", 32'(tx_data), 32'(8'hEF));
        drain("drainWord1", 500);
        check("word1Starts", 32'(starts - base), 32'(FRAME));
        check("word1Count", 32'(sentLog.size()), 32'(FRAME));
        for (int i = 0; i < int'(FRAME) && i < sentLog.size(); i++) begin
            check("word1Byte", 32'(sentLog[i]), 32'(exp1[i]));
        end

        // MSB-first instance: 0x01020304.
        wordValidM = 1'b1; wordDataM = 32'h01020304;
        tick();
        wordValidM = 1'b0;
        n = 0;
        while (sentM.size() < int'(FRAME) && n < 300) begin
            tick();
            n++;
        end
        repeat (10) tick();
        check("msbCount", 32'(sentM.size()), 32'(FRAME));
        for (int i = 0; i < int'(FRAME) && i < sentM.size(); i++) begin
            check("msbByte", 32'(sentM[i]), 32'(exp4[i]));
        end

        // Burst into a slow link: five accepted, later pushes dropped and flagged.
        kCycles = 100;
        for (int i = 0; i < 6; i++) begin
            word_valid = 1'b1; word_data = 32'hC0DE0000 + 32'(i);
            tick();
            if (i == 4) check("burstFullAfter5", 32'(word_ready), 32'(0));
        end
        check("burstOverflow6", 32'(overflow), 32'(1));
        word_valid = 1'b0;
        tick();
        check("burstOverflowPulse", 32'(overflow), 32'(0));
        word_valid = 1'b1; word_data = 32'hBADBAD00;
        tick();
        word_valid = 1'b0;
        check("burstOverflow7", 32'(overflow), 32'(1));
        drain("drainBurst", 3000);

        // Reset while the second byte is in flight.
        kCycles = 10;
        word_valid = 1'b1; word_data = 32'h11223344;
        tick();
        word_valid = 1'b0;
        n = 0;
        while (bytesSent < 2 && n < 200) begin
            tick();
            n++;
        end
        check("rstReachByte2", 32'(n < 200), 32'(1));
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstStart", 32'(tx_start), 32'(0));
        check("rstOverflow", 32'(overflow), 32'(0));
        check("rstReady", 32'(word_ready), 32'(1));
        check("rstIdleBusy", 32'(idle), 32'(0));
        n = 0;
        while (tx_busy && n < 100) begin
            tick();
            n++;
        end
        base = starts;
        word_valid = 1'b1; word_data = 32'hA5C30F96;
        tick();
        word_valid = 1'b0;
        drain("drainAfterRst", 500);
        check("rstNewStarts", 32'(starts - base), 32'(FRAME));

        // Random push/stall/K traffic.
        for (int i = 0; i < 600; i++) begin
            kCycles    = int'($urandom_range(1, 6));
            word_valid = ($urandom_range(0, 99) < 30);
            word_data  = $urandom();
            tick();
        end
        word_valid = 1'b0;
        drain("drainRandom", 5000);
        check("randomQueueEmpty", 32'(expQ.size()), 32'(0));
        check("randomIdleEnd", 32'(idle), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
